// File: rtl/pipe_hazard_pkg.sv
// -----------------------------------------------------------------------------
// pipe_hazard_pkg
// Shared types and constants for the pipelined core's hazard controller.
//   - Forward-select encodings driven onto the EX operand muxes.
//   - Stage indices. Index 0 is ID; slot k tracks the instruction in the
//     pipeline register that feeds stage k.
//   - Per-slot destination metadata struct and the "live producer" test.
// The rd field is sized for the widest supported register file (MAX_REG_AW);
// narrower REG_AW values are zero-extended into it.
// -----------------------------------------------------------------------------
package pipe_hazard_pkg;

  localparam int MAX_REG_AW = 8;

  localparam logic [2:0] FWD_RF    = 3'd0;
  localparam logic [2:0] FWD_EXMEM = 3'd1;
  localparam logic [2:0] FWD_MEMWB = 3'd2;

  localparam int STG_ID  = 0;
  localparam int STG_EX  = 1;
  localparam int STG_MEM = 2;
  localparam int STG_WB  = 3;

  typedef struct packed {
    logic                  valid;
    logic [MAX_REG_AW-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } hazSlotT;

  // A slot can only feed a consumer if it really writes a non-x0 register
  function automatic logic isLive(input hazSlotT s);
    return s.valid & s.regwrite & (s.rd != '0);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_haz_slot.sv
// -----------------------------------------------------------------------------
// haz_slot
// One metadata slot of the hazard tracker: a register holding valid, rd,
// regwrite and memread of the instruction sitting in one pipeline register.
// Ports:
//   clk, rst  - core clock, synchronous active-high reset (empties the slot)
//   load      - capture slotIn this cycle
//   kill      - turn the captured (or held) entry into a bubble
//   slotIn    - metadata arriving from the previous stage
//   slotOut   - metadata currently held
// -----------------------------------------------------------------------------
module haz_slot
  import pipe_hazard_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    kill,
  input  hazSlotT slotIn,
  output hazSlotT slotOut
);

  // Register the incoming metadata; a kill only clears the valid bit so the
  // rest of the fields simply ride along as don't-care data.
  always_ff @(posedge clk) begin
    if (rst) begin
      slotOut <= '0;
    end else if (load) begin
      slotOut <= '{valid:    slotIn.valid & ~kill,
                   rd:       slotIn.rd,
                   regwrite: slotIn.regwrite,
                   memread:  slotIn.memread};
    end else if (kill) begin
      slotOut.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard controller for the pipelined RISC-V core. Tracks destination
// metadata of every in-flight instruction from EX to the last stage and
// produces load-use stalls, branch-redirect flushes and EX forwarding selects.
// Parameters:
//   NUM_STAGES   (3..8)                tracked stages after IF, 0=ID
//   REG_AW       (<= MAX_REG_AW)       register address width
//   BRANCH_STAGE (1..NUM_STAGES-2)     stage whose input register resolves branches
//   LOAD_AVAIL   (2..NUM_STAGES-1)     first stage whose input register has load data
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   id_*_i                   decoded fields of the instruction in ID
//   br_taken_i               branch at BRANCH_STAGE redirects PC this cycle
//   pc_hold_o, ifid_hold_o   freeze PC and IF/ID
//   idex_bubble_o            load NOP control into ID/EX
//   flush_o                  bit i zeroes control of pipeline register i
//   fwd_a_o, fwd_b_o         EX operand select, 0=regfile, k=register feeding stage k+1
//   stall_cnt_o, flush_cnt_o performance counters
// Optional feature macro: HAZ_PERF_CNT_EN enables the saturating counters;
// without it both counter ports are tied to zero.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int REG_AW       = 5,
  parameter int BRANCH_STAGE = 2,
  parameter int LOAD_AVAIL   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid_i,
  input  logic [REG_AW-1:0]     id_rs1_i,
  input  logic [REG_AW-1:0]     id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_AW-1:0]     id_rd_i,
  input  logic                  id_regwrite_i,
  input  logic                  id_memread_i,
  input  logic                  br_taken_i,
  output logic                  pc_hold_o,
  output logic                  ifid_hold_o,
  output logic                  idex_bubble_o,
  output logic [BRANCH_STAGE:0] flush_o,
  output logic [2:0]            fwd_a_o,
  output logic [2:0]            fwd_b_o,
  output logic [31:0]           stall_cnt_o,
  output logic [31:0]           flush_cnt_o
);

  hazSlotT                 slots   [1:NUM_STAGES-1];
  hazSlotT                 slotD   [1:NUM_STAGES-1];
  logic [NUM_STAGES-1:1]   killVec;
  logic [MAX_REG_AW-1:0]   idRs1Ext, idRs2Ext, idRdExt;
  logic [MAX_REG_AW-1:0]   exRs1, exRs2;
  logic                    exUse1, exUse2;
  logic                    loadUse;
  logic                    stall;
  logic [2:0]              fwdA, fwdB;

  // Widen ID register fields into the package-wide rd width and build the
  // slot chain inputs. Slot 1 takes ID; later slots shift from their
  // neighbour. A stall or a redirect turns the ID entry into a bubble, and a
  // redirect also kills everything younger than the resolving branch.
  always_comb begin
    idRs1Ext = '0;
    idRs2Ext = '0;
    idRdExt  = '0;
    idRs1Ext[REG_AW-1:0] = id_rs1_i;
    idRs2Ext[REG_AW-1:0] = id_rs2_i;
    idRdExt[REG_AW-1:0]  = id_rd_i;

    killVec = '0;
    slotD[STG_EX] = '{valid: id_valid_i, rd: idRdExt,
                      regwrite: id_regwrite_i, memread: id_memread_i};
    killVec[STG_EX] = stall | br_taken_i;
    for (int k = STG_EX + 1; k < NUM_STAGES; k++) begin
      slotD[k] = slots[k-1];
      if (k <= BRANCH_STAGE) killVec[k] = br_taken_i;
    end
  end

  for (genvar k = 1; k < NUM_STAGES; k++) begin : gSlot
    haz_slot slotReg (
      .clk    (clk),
      .rst    (rst),
      .load   (1'b1),
      .kill   (killVec[k]),
      .slotIn (slotD[k]),
      .slotOut(slots[k])
    );
  end

  // Slot 1 also remembers which sources the EX instruction reads, since the
  // forwarding selects are computed for the instruction now in EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      exRs1  <= '0;
      exRs2  <= '0;
      exUse1 <= 1'b0;
      exUse2 <= 1'b0;
    end else begin
      exRs1  <= idRs1Ext;
      exRs2  <= idRs2Ext;
      exUse1 <= id_use_rs1_i;
      exUse2 <= id_use_rs2_i;
    end
  end

  // Load-use detection: a load whose data cannot yet reach EX by the time the
  // ID instruction gets there (k+1 < LOAD_AVAIL) must hold ID. A redirect
  // wins because the ID instruction is being thrown away anyway.
  always_comb begin
    loadUse = 1'b0;
    for (int k = 1; k < NUM_STAGES; k++) begin
      if (isLive(slots[k]) && slots[k].memread && ((k + 1) < LOAD_AVAIL) &&
          ((id_use_rs1_i && (slots[k].rd == idRs1Ext)) ||
           (id_use_rs2_i && (slots[k].rd == idRs2Ext))))
        loadUse = 1'b1;
    end
    stall = id_valid_i & loadUse & ~br_taken_i;
  end

  // Forwarding scan runs oldest to youngest so the youngest live match
  // overwrites older ones. Loads are skipped until their data is present.
  always_comb begin
    fwdA = FWD_RF;
    fwdB = FWD_RF;
    for (int k = NUM_STAGES - 1; k >= STG_MEM; k--) begin
      if (isLive(slots[k]) && !(slots[k].memread && (k < LOAD_AVAIL))) begin
        if (exUse1 && (exRs1 != '0) && (slots[k].rd == exRs1))
          fwdA = FWD_EXMEM + 3'(k - STG_MEM);
        if (exUse2 && (exRs2 != '0) && (slots[k].rd == exRs2))
          fwdB = FWD_EXMEM + 3'(k - STG_MEM);
      end
    end
  end

  assign pc_hold_o     = stall;
  assign ifid_hold_o   = stall;
  assign idex_bubble_o = stall;
  assign flush_o       = {(BRANCH_STAGE + 1){br_taken_i}};
  assign fwd_a_o       = fwdA;
  assign fwd_b_o       = fwdB;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stallCnt, flushCnt;

  // Saturating event counters: stall cycles and redirect cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stall && (stallCnt != '1))      stallCnt <= stallCnt + 32'd1;
      if (br_taken_i && (flushCnt != '1)) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign stall_cnt_o = stallCnt;
  assign flush_cnt_o = flushCnt;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl: a default-configured instance
// (4 stages, LOAD_AVAIL=3) and a deeper one (5 stages, LOAD_AVAIL=4) share
// the same ID stimulus. Inputs are driven 1 time unit after the rising edge
// and outputs are sampled 1 unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        idValid, idUse1, idUse2, idRegwrite, idMemread, brTaken;
  logic [4:0]  idRs1, idRs2, idRd;

  logic        pcHold, ifidHold, idexBubble;
  logic [2:0]  flush, fwdA, fwdB;
  logic [31:0] stallCnt, flushCnt;

  logic        deepPcHold, deepIfidHold, deepIdexBubble;
  logic [2:0]  deepFlush, deepFwdA, deepFwdB;
  logic [31:0] deepStallCnt, deepFlushCnt;

  int checks = 0;
  int passes = 0;
  int expStall = 0;
  int expFlush = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid_i(idValid), .id_rs1_i(idRs1), .id_rs2_i(idRs2),
    .id_use_rs1_i(idUse1), .id_use_rs2_i(idUse2), .id_rd_i(idRd),
    .id_regwrite_i(idRegwrite), .id_memread_i(idMemread), .br_taken_i(brTaken),
    .pc_hold_o(pcHold), .ifid_hold_o(ifidHold), .idex_bubble_o(idexBubble),
    .flush_o(flush), .fwd_a_o(fwdA), .fwd_b_o(fwdB),
    .stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
  );

  pipe_hazard_ctrl #(.NUM_STAGES(5), .REG_AW(5), .BRANCH_STAGE(2), .LOAD_AVAIL(4)) deepDut (
    .clk(clk), .rst(rst),
    .id_valid_i(idValid), .id_rs1_i(idRs1), .id_rs2_i(idRs2),
    .id_use_rs1_i(idUse1), .id_use_rs2_i(idUse2), .id_rd_i(idRd),
    .id_regwrite_i(idRegwrite), .id_memread_i(idMemread), .br_taken_i(brTaken),
    .pc_hold_o(deepPcHold), .ifid_hold_o(deepIfidHold), .idex_bubble_o(deepIdexBubble),
    .flush_o(deepFlush), .fwd_a_o(deepFwdA), .fwd_b_o(deepFwdB),
    .stall_cnt_o(deepStallCnt), .flush_cnt_o(deepFlushCnt)
  );

  // Drive one decoded ID instruction plus the branch-redirect input
  task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic br);
    idValid = v; idRs1 = rs1; idRs2 = rs2; idUse1 = u1; idUse2 = u2;
    idRd = rd; idRegwrite = rw; idMemread = mr; brTaken = br;
  endtask

  task automatic nop();
    applyStimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nop();
    tick();
    tick();
    #1;
    expStall = 0;
    expFlush = 0;
    checks++;
    if ({pcHold, ifidHold, idexBubble} !== 3'b000)
      $display("[TB] FAIL reset_holds: got %b expected 000", {pcHold, ifidHold, idexBubble});
    else passes++;
    checks++;
    if (flush !== 3'b000) $display("[TB] FAIL reset_flush: got %b expected 000", flush);
    else passes++;
    checks++;
    if ({fwdA, fwdB} !== 6'd0) $display("[TB] FAIL reset_fwd: got %0d/%0d expected 0/0", fwdA, fwdB);
    else passes++;
    checks++;
    if ({stallCnt, flushCnt} !== 64'd0)
      $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", stallCnt, flushCnt);
    else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    // lw x5, 0(x2)
    applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    checks++;
    if (pcHold !== 1'b0) $display("[TB] FAIL loaduse_idle: got %b expected 0", pcHold);
    else passes++;
    tick();
    // add x6, x5, x1 meets the load one stage ahead
    applyStimulus(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    expStall++;
    checks++;
    if ({pcHold, ifidHold, idexBubble, flush} !== 6'b111_000)
      $display("[TB] FAIL loaduse_stall: got %b expected 111000", {pcHold, ifidHold, idexBubble, flush});
    else passes++;
    tick();
    #1;
    checks++;
    if ({pcHold, ifidHold, idexBubble} !== 3'b000)
      $display("[TB] FAIL loaduse_release: got %b expected 000", {pcHold, ifidHold, idexBubble});
    else passes++;
    tick();
    nop();
    #1;
    checks++;
    if ({fwdA, fwdB} !== {3'd2, 3'd0})
      $display("[TB] FAIL loaduse_fwd: got %0d/%0d expected 2/0", fwdA, fwdB);
    else passes++;
    checks++;
    if (stallCnt !== (PERF ? 32'(expStall) : 32'd0))
      $display("[TB] FAIL loaduse_stall_cnt: got %0d expected %0d", stallCnt, PERF ? expStall : 0);
    else passes++;
    drain();
  endtask

  task automatic test_back_to_back();
    // add x5, x1, x2 then sub x7, x5, x5
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (pcHold !== 1'b0) $display("[TB] FAIL alu_no_stall: got %b expected 0", pcHold);
    else passes++;
    tick();
    nop();
    #1;
    checks++;
    if ({fwdA, fwdB} !== {3'd1, 3'd1})
      $display("[TB] FAIL alu_fwd: got %0d/%0d expected 1/1", fwdA, fwdB);
    else passes++;
    drain();
  endtask

  task automatic test_double_producer();
    // Two writers of x5, then a reader of x5 and x0
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    #1;
    checks++;
    if ({fwdA, fwdB} !== {3'd1, 3'd0})
      $display("[TB] FAIL double_youngest: got %0d/%0d expected 1/0", fwdA, fwdB);
    else passes++;
    drain();
    // Writer of x0 followed by a reader of x0
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    #1;
    checks++;
    if ({fwdA, fwdB} !== 6'd0) $display("[TB] FAIL x0_writer: got %0d/%0d expected 0/0", fwdA, fwdB);
    else passes++;
    drain();
    // Non-writing instruction with rd=x9, then reader of x9
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    #1;
    checks++;
    if (fwdA !== 3'd0) $display("[TB] FAIL no_regwrite: got %0d expected 0", fwdA);
    else passes++;
    drain();
    // Producer of x5, consumer names x5 but does not read it
    applyStimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd5, 5'd5, 1'b0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    nop();
    #1;
    checks++;
    if ({fwdA, fwdB} !== {3'd0, 3'd1})
      $display("[TB] FAIL use_bit: got %0d/%0d expected 0/1", fwdA, fwdB);
    else passes++;
    drain();
  endtask

  task automatic test_branch_load_use();
    applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    // Load-use condition present while the branch redirects
    applyStimulus(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    #1;
    expFlush++;
    checks++;
    if ({pcHold, ifidHold, idexBubble, flush} !== 6'b000_111)
      $display("[TB] FAIL branch_priority: got %b expected 000111", {pcHold, ifidHold, idexBubble, flush});
    else passes++;
    tick();
    // Reader of x5 and x6: both producers were flushed
    applyStimulus(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if ({pcHold, flush} !== 4'b0000)
      $display("[TB] FAIL branch_after: got %b expected 0000", {pcHold, flush});
    else passes++;
    checks++;
    if (flushCnt !== (PERF ? 32'(expFlush) : 32'd0))
      $display("[TB] FAIL branch_flush_cnt: got %0d expected %0d", flushCnt, PERF ? expFlush : 0);
    else passes++;
    checks++;
    if (stallCnt !== (PERF ? 32'(expStall) : 32'd0))
      $display("[TB] FAIL branch_stall_cnt: got %0d expected %0d", stallCnt, PERF ? expStall : 0);
    else passes++;
    tick();
    nop();
    #1;
    checks++;
    if ({fwdA, fwdB} !== 6'd0)
      $display("[TB] FAIL branch_killed_slots: got %0d/%0d expected 0/0", fwdA, fwdB);
    else passes++;
    drain();
  endtask

  task automatic test_rst_mid_stall();
    applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if (pcHold !== 1'b1) $display("[TB] FAIL rst_pre_stall: got %b expected 1", pcHold);
    else passes++;
    rst = 1'b1;
    tick();
    expStall = 0;
    expFlush = 0;
    #1;
    checks++;
    if ({pcHold, ifidHold, idexBubble, flush} !== 6'd0)
      $display("[TB] FAIL rst_mid_holds: got %b expected 000000", {pcHold, ifidHold, idexBubble, flush});
    else passes++;
    checks++;
    if ({fwdA, fwdB} !== 6'd0) $display("[TB] FAIL rst_mid_fwd: got %0d/%0d expected 0/0", fwdA, fwdB);
    else passes++;
    checks++;
    if ({stallCnt, flushCnt} !== 64'd0)
      $display("[TB] FAIL rst_mid_counters: got %0d/%0d expected 0/0", stallCnt, flushCnt);
    else passes++;
    rst = 1'b0;
    drain();
  endtask

  task automatic test_deep_pipe();
    rst = 1'b1;
    nop();
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    #1;
    checks++;
    if ({deepPcHold, deepIfidHold, deepIdexBubble} !== 3'b111)
      $display("[TB] FAIL deep_stall1: got %b expected 111", {deepPcHold, deepIfidHold, deepIdexBubble});
    else passes++;
    tick();
    #1;
    checks++;
    if ({deepPcHold, deepIfidHold, deepIdexBubble} !== 3'b111)
      $display("[TB] FAIL deep_stall2: got %b expected 111", {deepPcHold, deepIfidHold, deepIdexBubble});
    else passes++;
    tick();
    #1;
    checks++;
    if ({deepPcHold, deepFlush} !== 4'b0000)
      $display("[TB] FAIL deep_release: got %b expected 0000", {deepPcHold, deepFlush});
    else passes++;
    tick();
    nop();
    #1;
    checks++;
    if ({deepFwdA, deepFwdB} !== {3'd3, 3'd0})
      $display("[TB] FAIL deep_fwd: got %0d/%0d expected 3/0", deepFwdA, deepFwdB);
    else passes++;
    checks++;
    if ({deepStallCnt, deepFlushCnt} !== {(PERF ? 32'd2 : 32'd0), 32'd0})
      $display("[TB] FAIL deep_counters: got %0d/%0d expected %0d/0", deepStallCnt, deepFlushCnt, PERF ? 2 : 0);
    else passes++;
    drain();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_back_to_back();
    test_double_producer();
    test_branch_load_use();
    test_rst_mid_stall();
    test_deep_pipe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Guard against a bench that never reaches its end
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
